// File: rtl/mem_port_arbiter.sv
// Shares the memory read port between fetch and load/store, routing each 1-cycle-latency response to its owner.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority on conflicting reads (default: data wins).
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             f_req_valid_i,
  input  logic [AW-1:0]    f_req_addr_i,
  output logic             f_req_ready_o,
  output logic             f_rsp_valid_o,
  output logic [WIDTH-1:0] f_rsp_rdata_o,
  input  logic             d_req_valid_i,
  input  logic             d_req_we_i,
  input  logic [AW-1:0]    d_req_addr_i,
  input  logic [WIDTH-1:0] d_req_wdata_i,
  output logic             d_req_ready_o,
  output logic             d_rsp_valid_o,
  output logic [WIDTH-1:0] d_rsp_rdata_o,
  output logic             read_word_en_o,
  output logic [AW-1:0]    read_word_pos_o,
  input  logic [WIDTH-1:0] read_word_data_i,
  output logic             write_word_en_o,
  output logic [AW-1:0]    write_word_pos_o,
  output logic [WIDTH-1:0] write_word_data_o
);

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  logic   f_read, d_read, d_write;
  logic   grant_f, grant_d, grant_any;
  logic   rsp_pend_q, rsp_pend_d;
  owner_e rsp_owner_q, rsp_owner_d;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e rr_last_q, rr_last_d;
`endif

  always_comb begin
    f_read  = f_req_valid_i;
    d_read  = d_req_valid_i && !d_req_we_i;
    d_write = d_req_valid_i && d_req_we_i;
    grant_f = f_read;
    grant_d = d_read;
    // On conflict only one read may reach the memory; the loser simply sees ready low and retries.
    if (f_read && d_read) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_f = (rr_last_q == OWNER_DATA);
      grant_d = (rr_last_q == OWNER_FETCH);
`else
      grant_f = 1'b0;
      grant_d = 1'b1;
`endif
    end
    grant_any = grant_f || grant_d;

    f_req_ready_o   = grant_f;
    d_req_ready_o   = d_write || grant_d;
    read_word_en_o  = grant_any;
    read_word_pos_o = '0;
    if (grant_f) begin
      read_word_pos_o = f_req_addr_i;
    end else if (grant_d) begin
      read_word_pos_o = d_req_addr_i;
    end

    write_word_en_o   = d_write;
    write_word_pos_o  = d_req_addr_i;
    write_word_data_o = d_req_wdata_i;

    rsp_pend_d  = grant_any;
    rsp_owner_d = rsp_owner_q;
    if (grant_any) begin
      rsp_owner_d = grant_d ? OWNER_DATA : OWNER_FETCH;
    end
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d = rr_last_q;
    if (grant_any) begin
      rr_last_d = grant_d ? OWNER_DATA : OWNER_FETCH;
    end
`endif
  end

  // Reset drops any in-flight read so no stale response appears after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= OWNER_FETCH;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= OWNER_DATA;
`endif
    end else begin
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  always_comb begin
    f_rsp_valid_o = rsp_pend_q && (rsp_owner_q == OWNER_FETCH);
    d_rsp_valid_o = rsp_pend_q && (rsp_owner_q == OWNER_DATA);
    f_rsp_rdata_o = read_word_data_i;
    d_rsp_rdata_o = read_word_data_i;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory stub, reference model with per-cycle compare, directed vectors.
// Expected grant patterns follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_port_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             f_req_valid_i = 1'b0;
  logic [AW-1:0]    f_req_addr_i = '0;
  logic             f_req_ready_o;
  logic             f_rsp_valid_o;
  logic [WIDTH-1:0] f_rsp_rdata_o;
  logic             d_req_valid_i = 1'b0;
  logic             d_req_we_i = 1'b0;
  logic [AW-1:0]    d_req_addr_i = '0;
  logic [WIDTH-1:0] d_req_wdata_i = '0;
  logic             d_req_ready_o;
  logic             d_rsp_valid_o;
  logic [WIDTH-1:0] d_rsp_rdata_o;
  logic             read_word_en_o;
  logic [AW-1:0]    read_word_pos_o;
  logic [WIDTH-1:0] read_word_data;
  logic             write_word_en_o;
  logic [AW-1:0]    write_word_pos_o;
  logic [WIDTH-1:0] write_word_data_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .f_req_valid_i(f_req_valid_i), .f_req_addr_i(f_req_addr_i), .f_req_ready_o(f_req_ready_o),
    .f_rsp_valid_o(f_rsp_valid_o), .f_rsp_rdata_o(f_rsp_rdata_o),
    .d_req_valid_i(d_req_valid_i), .d_req_we_i(d_req_we_i), .d_req_addr_i(d_req_addr_i),
    .d_req_wdata_i(d_req_wdata_i), .d_req_ready_o(d_req_ready_o),
    .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_rdata_o(d_rsp_rdata_o),
    .read_word_en_o(read_word_en_o), .read_word_pos_o(read_word_pos_o),
    .read_word_data_i(read_word_data),
    .write_word_en_o(write_word_en_o), .write_word_pos_o(write_word_pos_o),
    .write_word_data_o(write_word_data_o)
  );

  // Memory stub: registered read, write data forwarded to a same-address read.
  logic [WIDTH-1:0] stub_mem [DEPTH];
  logic [WIDTH-1:0] ref_mem  [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      stub_mem[i] = 32'hA0 + i;
      ref_mem[i]  = 32'hA0 + i;
    end
  end

  always @(posedge clk) begin
    if (read_word_en_o) begin
      if (write_word_en_o && write_word_pos_o == read_word_pos_o)
        read_word_data <= write_word_data_o;
      else
        read_word_data <= stub_mem[read_word_pos_o];
    end
    if (write_word_en_o) stub_mem[write_word_pos_o] <= write_word_data_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: who should win this cycle, judged from the request inputs alone.
  bit               model_last_fetch = 1'b0;
  bit               exp_pend = 1'b0;
  bit               exp_owner_data = 1'b0;
  logic [WIDTH-1:0] exp_data = '0;

  function automatic void model_grant(output bit gf, output bit gd);
    bit fr, dr;
    fr = f_req_valid_i;
    dr = d_req_valid_i && !d_req_we_i;
    gf = fr;
    gd = dr;
    if (fr && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      gf = !model_last_fetch;
      gd = model_last_fetch;
`else
      gf = 1'b0;
      gd = 1'b1;
`endif
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit gf, gd;
    logic [AW-1:0] addr;
    if (!rst_n) begin
      exp_pend         <= 1'b0;
      model_last_fetch <= 1'b0;
    end else begin
      model_grant(gf, gd);
      exp_pend <= gf || gd;
      if (gf || gd) begin
        addr = gf ? f_req_addr_i : d_req_addr_i;
        exp_owner_data   <= gd;
        model_last_fetch <= gf;
        if (d_req_valid_i && d_req_we_i && d_req_addr_i == addr)
          exp_data <= d_req_wdata_i;
        else
          exp_data <= ref_mem[addr];
      end
      if (d_req_valid_i && d_req_we_i) ref_mem[d_req_addr_i] <= d_req_wdata_i;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit gf, gd, dw;
    model_grant(gf, gd);
    dw = d_req_valid_i && d_req_we_i;
    checkOutput("m_f_ready", f_req_ready_o, gf);
    checkOutput("m_d_ready", d_req_ready_o, gd || dw);
    checkOutput("m_read_en", read_word_en_o, gf || gd);
    checkOutput("m_read_pos", read_word_pos_o, gf ? f_req_addr_i : (gd ? d_req_addr_i : '0));
    checkOutput("m_write_en", write_word_en_o, dw);
    if (dw) begin
      checkOutput("m_write_pos", write_word_pos_o, d_req_addr_i);
      checkOutput("m_write_data", write_word_data_o, d_req_wdata_i);
    end
    checkOutput("m_f_rsp_valid", f_rsp_valid_o, exp_pend && !exp_owner_data);
    checkOutput("m_d_rsp_valid", d_rsp_valid_o, exp_pend && exp_owner_data);
    if (exp_pend && !exp_owner_data) checkOutput("m_f_rsp_rdata", f_rsp_rdata_o, exp_data);
    if (exp_pend && exp_owner_data)  checkOutput("m_d_rsp_rdata", d_rsp_rdata_o, exp_data);
  end

  task automatic applyStimulus(input bit fv, input logic [AW-1:0] fa, input bit dv, input bit dwe,
                               input logic [AW-1:0] da, input logic [WIDTH-1:0] dwd);
    @(posedge clk);
    #1;
    f_req_valid_i = fv;
    f_req_addr_i  = fa;
    d_req_valid_i = dv;
    d_req_we_i    = dwe;
    d_req_addr_i  = da;
    d_req_wdata_i = dwd;
  endtask

  logic [3:0] f_grants, f_rsps, d_rsps;
  logic [3:0] exp_f_grants, exp_f_rsps, exp_d_rsps;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_f_rsp_valid", f_rsp_valid_o, 0);
    checkOutput("reset_d_rsp_valid", d_rsp_valid_o, 0);

    // Single fetch read of address 5.
    applyStimulus(1, 5, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fetch5_ready", f_req_ready_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fetch5_rsp_valid", f_rsp_valid_o, 1);
    checkOutput("fetch5_rdata", f_rsp_rdata_o, 32'hA5);
    checkOutput("fetch5_d_rsp_valid", d_rsp_valid_o, 0);

    // Write and fetch to the same address in one cycle: fetch sees the new word.
    applyStimulus(1, 7, 1, 1, 7, 32'h1234);
    @(negedge clk);
    checkOutput("fwd_f_ready", f_req_ready_o, 1);
    checkOutput("fwd_d_ready", d_req_ready_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fwd_rdata", f_rsp_rdata_o, 32'h1234);

    // Back-to-back fetches of 0..3.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, AW'(i), 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("b2b_ready", f_req_ready_o, 1);
      if (i > 0) begin
        checkOutput("b2b_rsp_valid", f_rsp_valid_o, 1);
        checkOutput("b2b_rdata", f_rsp_rdata_o, 32'hA0 + i - 1);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("b2b_last_valid", f_rsp_valid_o, 1);
    checkOutput("b2b_last_rdata", f_rsp_rdata_o, 32'hA3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("b2b_idle_valid", f_rsp_valid_o, 0);

    // Data write alone never produces a read or a response.
    applyStimulus(0, 0, 1, 1, 9, 32'hBEEF);
    @(negedge clk);
    checkOutput("wr_d_ready", d_req_ready_o, 1);
    checkOutput("wr_write_en", write_word_en_o, 1);
    checkOutput("wr_read_en", read_word_en_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wr_d_rsp_valid", d_rsp_valid_o, 0);

    // Reset while a read is in flight.
    applyStimulus(1, 3, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    f_req_valid_i = 1'b0;
    #1;
    checkOutput("rst_inflight_f_valid", f_rsp_valid_o, 0);
    checkOutput("rst_inflight_d_valid", d_rsp_valid_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_f_valid", f_rsp_valid_o, 0);
    checkOutput("rst_release_d_valid", d_rsp_valid_o, 0);

    // Conflicting reads, fetch addr 1 vs data addr 2, four cycles straight after reset.
    f_grants = '0;
    f_rsps = '0;
    d_rsps = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 1, 0, 2, 0);
      @(negedge clk);
      f_grants[i] = f_req_ready_o;
      if (i > 0) begin
        f_rsps[i-1] = f_rsp_valid_o;
        d_rsps[i-1] = d_rsp_valid_o;
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    f_rsps[3] = f_rsp_valid_o;
    d_rsps[3] = d_rsp_valid_o;
`ifdef ARB_ROUND_ROBIN_EN
    exp_f_grants = 4'b0101;
    exp_f_rsps   = 4'b0101;
    exp_d_rsps   = 4'b1010;
`else
    exp_f_grants = 4'b0000;
    exp_f_rsps   = 4'b0000;
    exp_d_rsps   = 4'b1111;
`endif
    checkOutput("conflict_f_grants", f_grants, exp_f_grants);
    checkOutput("conflict_f_rsps", f_rsps, exp_f_rsps);
    checkOutput("conflict_d_rsps", d_rsps, exp_d_rsps);

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
